// File: rtl/spi_mnrch_pkg.sv
// Shared types for the multi-select SPI master.
// Holds the FSM state encoding and the per-frame mode bundle.
package spi_mnrch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRONT,
        XFER,
        BACK
    } state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

endpackage

// File: rtl/spi_multi_mnrch_if.sv
// Host request/response and serial pins of the SPI master.
// master: the SPI master core; slave: host plus attached serf.
interface spi_multi_mnrch_if #(
    parameter int DATA_W = 16,
    parameter int NUM_SS = 2,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
    logic              wrt;
    logic [DATA_W-1:0] wt_data;
    logic [SS_W-1:0]   ss_sel;
    logic              cpol;
    logic              cpha;
    logic              MISO;
    logic [NUM_SS-1:0] SS_n;
    logic              SCLK;
    logic              MOSI;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;

    modport master (
        input  wrt, wt_data, ss_sel, cpol, cpha, MISO,
        output SS_n, SCLK, MOSI, busy, done, rd_data
    );

    modport slave (
        output wrt, wt_data, ss_sel, cpol, cpha, MISO,
        input  SS_n, SCLK, MOSI, busy, done, rd_data
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: half-period tick, leading/trailing edge strobes
// and the registered SCLK level.
module spi_sclk_gen #(
    parameter int DIV_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic cpol_in,
    input  logic cpol,
    input  logic run,
    input  logic xfer,
    output logic tick,
    output logic lead,
    output logic trail,
    output logic sclk
);

    localparam int HW = DIV_W - 1;

    logic [HW-1:0] div;

    assign tick  = run && (div == '1);
    assign lead  = xfer && tick && (sclk == cpol);
    assign trail = xfer && tick && (sclk != cpol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            sclk <= 1'b0;
        end else if (load) begin
            div  <= '0;
            sclk <= cpol_in;
        end else if (run) begin
            div <= div + 1'b1;
            if (xfer && tick)
                sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_multi_mnrch.sv
// SPI master with NUM_SS active-low selects and per-frame mode.
// FSM, shift register and sample flop live here; timing in spi_sclk_gen.
module spi_multi_mnrch
    import spi_mnrch_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 5,
    parameter int NUM_SS = 2
) (
    input logic                clk,
    input logic                rst_n,
    spi_multi_mnrch_if.master  bus
);

    localparam int CNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * DATA_W - 1);

    state_e            state;
    mode_t             mode;
    logic [DATA_W-1:0] sr;
    logic              smp;
    logic [CNT_W-1:0]  ecnt;
    logic [NUM_SS-1:0] ss_n;
    logic              busy;
    logic              done;

    logic load;
    logic run;
    logic xfer;
    logic tick;
    logic lead;
    logic trail;
    logic sclk;
    logic [DATA_W-1:0] shifted;

    assign load = (state == IDLE) && bus.wrt
                && (32'(bus.ss_sel) < NUM_SS);
    assign run  = (state != IDLE);
    assign xfer = (state == XFER);
    assign shifted = {sr[DATA_W-2:0], smp};

    spi_sclk_gen #(
        .DIV_W (DIV_W)
    ) u_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .cpol_in (bus.cpol),
        .cpol    (mode.cpol),
        .run     (run),
        .xfer    (xfer),
        .tick    (tick),
        .lead    (lead),
        .trail   (trail),
        .sclk    (sclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode  <= '0;
            sr    <= '0;
            smp   <= 1'b0;
            ecnt  <= '0;
            ss_n  <= '1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        mode  <= '{cpol: bus.cpol, cpha: bus.cpha};
                        sr    <= bus.wt_data;
                        ecnt  <= '0;
                        ss_n  <= ~(NUM_SS'(1) << bus.ss_sel);
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= FRONT;
                    end
                end
                FRONT: begin
                    if (tick)
                        state <= XFER;
                end
                XFER: begin
                    // The final shift is deferred to the end of BACK.
                    if (lead) begin
                        if (!mode.cpha)
                            smp <= bus.MISO;
                        else if (ecnt != '0)
                            sr <= shifted;
                    end
                    if (trail) begin
                        if (mode.cpha)
                            smp <= bus.MISO;
                        else if (ecnt != LAST)
                            sr <= shifted;
                    end
                    if (lead || trail) begin
                        ecnt <= ecnt + 1'b1;
                        if (ecnt == LAST)
                            state <= BACK;
                    end
                end
                BACK: begin
                    if (tick) begin
                        sr    <= shifted;
                        ss_n  <= '1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.SS_n    = ss_n;
    assign bus.SCLK    = sclk;
    assign bus.MOSI    = sr[DATA_W-1];
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rd_data = sr;

endmodule

// File: tb/tb_spi_multi_mnrch.sv
// Scoreboard bench for spi_multi_mnrch: 16-bit/2-select and
// 8-bit/3-select instances, loopback and a modelled serf.
module tb_spi_multi_mnrch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic loop_a;

    spi_multi_mnrch_if #(.DATA_W(16), .NUM_SS(2)) ba ();
    spi_multi_mnrch_if #(.DATA_W(8),  .NUM_SS(3)) bb ();

    spi_multi_mnrch #(
        .DATA_W (16),
        .DIV_W  (5),
        .NUM_SS (2)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (ba)
    );

    spi_multi_mnrch #(
        .DATA_W (8),
        .DIV_W  (3),
        .NUM_SS (3)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bb)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Serf model: shifts s_data out MSB first in the current mode.
    logic [15:0] s_data = 16'h1234;
    logic        s_miso = 1'b0;
    bit          s_pol  = 1'b0;
    bit          s_pha  = 1'b0;
    int          s_idx  = 15;
    int          s_e    = 0;
    wire         ss_all = &ba.SS_n;

    always @(negedge ss_all) begin
        s_idx  = 15;
        s_e    = 0;
        s_miso = s_data[15];
    end

    always @(ba.SCLK) begin
        if (!ss_all) begin
            if (ba.SCLK != s_pol) begin
                s_e++;
                if (s_pha && s_idx >= 0) begin
                    s_miso = s_data[s_idx];
                    s_idx--;
                end
            end else if (s_e % 2 == 1) begin
                s_e++;
                if (!s_pha) begin
                    s_idx--;
                    if (s_idx >= 0)
                        s_miso = s_data[s_idx];
                end
            end
        end
    end

    assign ba.MISO = loop_a ? ba.MOSI : s_miso;
    assign bb.MISO = bb.MOSI;

    typedef struct {
        logic [31:0] data;
        int          lat;
        string       nm;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Latency = accept edge through done edge, both inclusive.
    int   ta = 0;
    int   tb = 0;
    logic pa_busy = 1'b0;
    logic pa_done = 1'b0;
    logic pb_busy = 1'b0;
    logic pb_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (ba.busy === 1'b1 && pa_busy !== 1'b1)
            ta = cyc;
        if (ba.done === 1'b1 && pa_done !== 1'b1) begin
            if (qa.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected_done: got done=1 required no frame");
            end else begin
                e = qa.pop_front();
                chk({e.nm, "_rd"}, 64'(ba.rd_data), 64'(e.data));
                chk({e.nm, "_lat"}, 64'(cyc - ta + 1), 64'(e.lat));
            end
        end
        pa_busy = ba.busy;
        pa_done = ba.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bb.busy === 1'b1 && pb_busy !== 1'b1)
            tb = cyc;
        if (bb.done === 1'b1 && pb_done !== 1'b1) begin
            if (qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected_done: got done=1 required no frame");
            end else begin
                e = qb.pop_front();
                chk({e.nm, "_rd"}, 64'(bb.rd_data), 64'(e.data));
                chk({e.nm, "_lat"}, 64'(cyc - tb + 1), 64'(e.lat));
            end
        end
        pb_busy = bb.busy;
        pb_done = bb.done;
    end

    task automatic start_a(logic [15:0] d, logic sel, logic pol,
                           logic pha, logic [15:0] exp, string nm);
        @(negedge clk);
        s_pol      = pol;
        s_pha      = pha;
        ba.wt_data = d;
        ba.ss_sel  = sel;
        ba.cpol    = pol;
        ba.cpha    = pha;
        ba.wrt     = 1'b1;
        qa.push_back('{32'(exp), 545, nm});
        @(negedge clk);
        ba.wrt = 1'b0;
    endtask

    task automatic wait_a(string nm);
        int n = 0;
        while (ba.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (ba.done !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done required done", nm);
        end
    endtask

    task automatic wait_b(string nm);
        int n = 0;
        while (bb.done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (bb.done !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done required done", nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end required end of test");
        $fatal(1);
    end

    initial begin
        ba.wrt = 0; ba.wt_data = '0; ba.ss_sel = '0;
        ba.cpol = 0; ba.cpha = 0;
        bb.wrt = 0; bb.wt_data = '0; bb.ss_sel = '0;
        bb.cpol = 0; bb.cpha = 0;
        loop_a = 1'b0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss", 64'(ba.SS_n), 64'(2'b11));
        chk("rst_sclk", 64'(ba.SCLK), 64'(0));
        chk("rst_busy", 64'(ba.busy), 64'(0));
        chk("rst_done", 64'(ba.done), 64'(0));
        chk("rst_rd", 64'(ba.rd_data), 64'(0));
        chk("rst_b_ss", 64'(bb.SS_n), 64'(3'b111));
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);

        // Mode 3 loopback on select 0.
        loop_a = 1'b1;
        start_a(16'hA5C3, 1'b0, 1'b1, 1'b1, 16'hA5C3, "m3_loop");
        repeat (100) @(negedge clk);
        chk("m3_ss", 64'(ba.SS_n), 64'(2'b10));
        chk("m3_busy", 64'(ba.busy), 64'(1));
        wait_a("m3_loop");

        // All four modes against the serf on select 1.
        loop_a = 1'b0;
        for (int m = 0; m < 4; m++) begin
            logic [1:0] mv;
            mv = 2'(m);
            start_a(16'hC0DE, 1'b1, mv[1], mv[0], 16'h1234,
                    $sformatf("mode%0d", m));
            chk($sformatf("mode%0d_sclk_front", m), 64'(ba.SCLK), 64'(mv[1]));
            repeat (200) @(negedge clk);
            chk($sformatf("mode%0d_ss", m), 64'(ba.SS_n), 64'(2'b01));
            wait_a($sformatf("mode%0d", m));
            @(negedge clk);
            chk($sformatf("mode%0d_sclk_idle", m), 64'(ba.SCLK), 64'(mv[1]));
        end

        // wrt mid-frame must not disturb the running frame.
        loop_a = 1'b1;
        start_a(16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0F0F, "midwrt");
        repeat (50) @(negedge clk);
        ba.wt_data = 16'hFFFF;
        ba.ss_sel  = 1'b1;
        ba.cpol    = 1'b1;
        ba.cpha    = 1'b1;
        ba.wrt     = 1'b1;
        @(negedge clk);
        ba.wrt = 1'b0;
        chk("midwrt_ss", 64'(ba.SS_n), 64'(2'b10));
        chk("midwrt_sclk", 64'(ba.SCLK), 64'(0));
        wait_a("midwrt");
        repeat (20) @(negedge clk);
        chk("midwrt_no_new_busy", 64'(ba.busy), 64'(0));
        chk("midwrt_no_new_ss", 64'(ba.SS_n), 64'(2'b11));
        chk("midwrt_done_held", 64'(ba.done), 64'(1));

        // Asynchronous reset around SCLK edge 10 of a frame.
        start_a(16'h5555, 1'b1, 1'b0, 1'b0, 16'h5555, "rst_abort");
        repeat (11 * 16 - 1) @(negedge clk);
        #2;
        rst_a = 1'b0;
        qa.delete();
        #1;
        chk("arst_ss", 64'(ba.SS_n), 64'(2'b11));
        chk("arst_busy", 64'(ba.busy), 64'(0));
        chk("arst_done", 64'(ba.done), 64'(0));
        chk("arst_sclk", 64'(ba.SCLK), 64'(0));
        chk("arst_rd", 64'(ba.rd_data), 64'(0));
        @(negedge clk);
        rst_a = 1'b1;
        start_a(16'h3C96, 1'b0, 1'b0, 1'b1, 16'h3C96, "post_rst");
        wait_a("post_rst");

        // 8-bit instance: back-to-back frames on the top select.
        @(negedge clk);
        bb.wt_data = 8'h81;
        bb.ss_sel  = 2'd2;
        bb.cpol    = 1'b0;
        bb.cpha    = 1'b0;
        bb.wrt     = 1'b1;
        qb.push_back('{32'h81, 73, "b_f1"});
        @(negedge clk);
        bb.wrt = 1'b0;
        chk("b_f1_ss", 64'(bb.SS_n), 64'(3'b011));
        // Hold wrt across the done edge: that edge ignores it,
        // the following one accepts the second frame.
        repeat (68) @(negedge clk);
        bb.cpol = 1'b1;
        bb.cpha = 1'b1;
        bb.wrt  = 1'b1;
        qb.push_back('{32'h81, 73, "b_f2"});
        wait_b("b_f1");
        chk("b_f1_done_busy", 64'(bb.busy), 64'(0));
        @(negedge clk);
        bb.wrt = 1'b0;
        chk("b_f2_accept", 64'(bb.busy), 64'(1));
        chk("b_f2_sclk", 64'(bb.SCLK), 64'(1));
        wait_b("b_f2");

        // Out-of-range select is ignored.
        @(negedge clk);
        bb.ss_sel = 2'd3;
        bb.wrt    = 1'b1;
        @(negedge clk);
        bb.wrt = 1'b0;
        repeat (3) @(negedge clk);
        chk("bad_sel_ss", 64'(bb.SS_n), 64'(3'b111));
        chk("bad_sel_done", 64'(bb.done), 64'(1));
        chk("bad_sel_busy", 64'(bb.busy), 64'(0));

        repeat (5) @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d pending required 0",
                     qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
